acc_rf_wr_arbiter: RTL and testbench

- Shares the single CPU register-file (x0..x31) write port between two requesters: CPU writeback (load/immediate results) and accelerator result writes (waddr/wdata/wren from acc_top).
- CPU writeback has absolute priority and is never stalled.
- Accelerator writes that lose arbitration are held in a small ordered buffer and drained in idle write slots.
- Provides read bypass so accelerator operand reads (raddr_o of acc_top) see buffered, not-yet-committed results.

---
 rtl/acc_pkg.sv | 17 +
 rtl/acc_wr_fifo.sv | 74 +++++++
 rtl/acc_rf_wr_arbiter.sv | 106 ++++++++++
 tb/tb_acc_rf_wr_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared accelerator types: register-file address/data and the write bundle
// used both for buffered entries and for the register-file write port.
package acc_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    data_t     data;
  } rf_wr_t;

endpackage

// File: rtl/acc_wr_fifo.sv
// Ordered buffer of accelerator writes with kill-by-address and a
// youngest-valid-match lookup used for read bypass.
module acc_wr_fifo
  import acc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  rf_wr_t           push_data_i,
  input  logic             pop_i,
  input  logic             kill_i,
  input  reg_addr_t        kill_addr_i,
  input  reg_addr_t        lookup_addr_i,
  output rf_wr_t           head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o,
  output logic             hit_o,
  output data_t            hit_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  rf_wr_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Kill is applied before the push so a same-edge push stays valid (it is newer).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[PTR_W'(i)] <= '0;
    end else begin
      if (kill_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[PTR_W'(i)].addr == kill_addr_i) mem[PTR_W'(i)].valid <= 1'b0;
        end
      end
      if (push_i) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_i) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Walk head to tail; the last valid match is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && mem[idx].valid && (mem[idx].addr == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = mem[idx].data;
      end
    end
  end

  assign head_o  = mem[rd_ptr];
  assign empty_o = (count == '0);
  assign full_o  = (count == CNT_W'(DEPTH));
  assign count_o = count;

endmodule

// File: rtl/acc_rf_wr_arbiter.sv
// Arbitrates the single register-file write port between CPU writeback
// (absolute priority) and buffered/fall-through accelerator writes.
module acc_rf_wr_arbiter
  import acc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_wren_i,
  input  reg_addr_t        cpu_waddr_i,
  input  data_t            cpu_wdata_i,
  input  logic             acc_wren_i,
  input  reg_addr_t        acc_waddr_i,
  input  data_t            acc_wdata_i,
  output logic             acc_wready_o,
  output logic             rf_wren_o,
  output reg_addr_t        rf_waddr_o,
  output data_t            rf_wdata_o,
  input  reg_addr_t        raddr_i,
  input  data_t            rf_rdata_i,
  output data_t            rdata_o,
  output logic             rvalid_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             busy_o
);

  rf_wr_t           port;
  rf_wr_t           head;
  rf_wr_t           push_data;
  logic             push;
  logic             pop;
  logic             fall;
  logic             kill;
  logic             empty;
  logic             full;
  logic             hit;
  data_t            hit_data;
  logic [CNT_W-1:0] count;

  acc_wr_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (push),
    .push_data_i   (push_data),
    .pop_i         (pop),
    .kill_i        (kill),
    .kill_addr_i   (cpu_waddr_i),
    .lookup_addr_i (raddr_i),
    .head_o        (head),
    .empty_o       (empty),
    .full_o        (full),
    .count_o       (count),
    .hit_o         (hit),
    .hit_data_o    (hit_data)
  );

  // Priority mux: CPU, then buffer head, then zero-latency fall-through.
  // x0 writes are swallowed; nothing commits while reset is asserted.
  always_comb begin
    port = '0;
    pop  = 1'b0;
    push = 1'b0;
    fall = 1'b0;
    if (!rst_i) begin
      if (cpu_wren_i) begin
        if (cpu_waddr_i != '0) begin
          port.valid = 1'b1;
          port.addr  = cpu_waddr_i;
          port.data  = cpu_wdata_i;
        end
      end else if (!empty) begin
        pop = 1'b1;
        if (head.valid) port = head;
      end else if (acc_wren_i && (acc_waddr_i != '0)) begin
        fall       = 1'b1;
        port.valid = 1'b1;
        port.addr  = acc_waddr_i;
        port.data  = acc_wdata_i;
      end
      push = acc_wren_i && !full && (acc_waddr_i != '0) && !fall;
    end
  end

  always_comb begin
    push_data       = '0;
    push_data.valid = 1'b1;
    push_data.addr  = acc_waddr_i;
    push_data.data  = acc_wdata_i;
  end

  assign kill         = !rst_i && cpu_wren_i && (cpu_waddr_i != '0);
  assign acc_wready_o = !full;
  assign rf_wren_o    = port.valid;
  assign rf_waddr_o   = port.addr;
  assign rf_wdata_o   = port.data;
  assign rdata_o      = hit ? hit_data : rf_rdata_i;
  assign rvalid_o     = (raddr_i != '0);
  assign pending_o    = count;
  assign busy_o       = (count != '0);

endmodule

// File: tb/tb_acc_rf_wr_arbiter.sv
// Directed and random checks of acc_rf_wr_arbiter against a queue-based model.
module tb_acc_rf_wr_arbiter;
  import acc_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_wren;
  reg_addr_t        cpu_waddr;
  data_t            cpu_wdata;
  logic             acc_wren;
  reg_addr_t        acc_waddr;
  data_t            acc_wdata;
  logic             acc_wready;
  logic             rf_wren;
  reg_addr_t        rf_waddr;
  data_t            rf_wdata;
  reg_addr_t        raddr;
  data_t            rf_rdata;
  data_t            rdata;
  logic             rvalid;
  logic [CNT_W-1:0] pending;
  logic             busy;

  always #5 clk = ~clk;

  acc_rf_wr_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpu_wren_i   (cpu_wren),
    .cpu_waddr_i  (cpu_waddr),
    .cpu_wdata_i  (cpu_wdata),
    .acc_wren_i   (acc_wren),
    .acc_waddr_i  (acc_waddr),
    .acc_wdata_i  (acc_wdata),
    .acc_wready_o (acc_wready),
    .rf_wren_o    (rf_wren),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .raddr_i      (raddr),
    .rf_rdata_i   (rf_rdata),
    .rdata_o      (rdata),
    .rvalid_o     (rvalid),
    .pending_o    (pending),
    .busy_o       (busy)
  );

  // Reference state: architectural register file and ordered pending writes.
  logic [31:0] model_rf [32];
  rf_wr_t      q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  assign rf_rdata = model_rf[raddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic cw, input logic [4:0] ca, input logic [31:0] cd,
                        input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                        input logic [4:0] ra);
    cpu_wren = cw; cpu_waddr = ca; cpu_wdata = cd;
    acc_wren = aw; acc_waddr = aa; acc_wdata = ad;
    raddr    = ra;
  endtask

  // Compare at the falling edge, then advance the model to the next rising edge.
  task automatic step(input bit chk_zero);
    bit          full;
    bit          fall;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] er;
    rf_wr_t      ent;
    #4;
    if (rst) begin
      check("rst_wren", 32'(rf_wren), 32'd0);
      q.delete();
    end else begin
      full = (q.size() == DEPTH);
      check("wready", 32'(acc_wready), 32'(!full));
      check("pending", 32'(pending), 32'(q.size()));
      check("busy", 32'(busy), 32'(q.size() != 0));
      er = model_rf[raddr];
      for (int i = 0; i < q.size(); i++)
        if (q[i].valid && q[i].addr == raddr) er = q[i].data;
      check("rvalid", 32'(rvalid), 32'(raddr != 0));
      check("rdata", rdata, er);
      ew = 1'b0; ea = '0; ed = '0; fall = 1'b0;
      if (cpu_wren) begin
        ew = (cpu_waddr != 0); ea = cpu_waddr; ed = cpu_wdata;
      end else if (q.size() > 0) begin
        ent = q.pop_front();
        ew = ent.valid; ea = ent.addr; ed = ent.data;
      end else if (acc_wren && acc_waddr != 0) begin
        ew = 1'b1; ea = acc_waddr; ed = acc_wdata; fall = 1'b1;
      end
      check("rf_wren", 32'(rf_wren), 32'(ew));
      if (ew) begin
        check("rf_waddr", 32'(rf_waddr), 32'(ea));
        check("rf_wdata", rf_wdata, ed);
      end
      if (chk_zero) begin
        check("idle_waddr", 32'(rf_waddr), 32'd0);
        check("idle_wdata", rf_wdata, 32'd0);
      end
      if (cpu_wren && cpu_waddr != 0) begin
        for (int i = 0; i < q.size(); i++) begin
          ent = q[i];
          if (ent.addr == cpu_waddr) ent.valid = 1'b0;
          q[i] = ent;
        end
      end
      if (acc_wren && !full && acc_waddr != 0 && !fall) begin
        ent.valid = 1'b1; ent.addr = acc_waddr; ent.data = acc_wdata;
        q.push_back(ent);
      end
      if (ew) model_rf[ea] = ed;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  k;
    bit  acc_take;
    for (int i = 0; i < 32; i++) model_rf[i] = (i == 0) ? 32'd0 : $urandom;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    step(1'b0);
    rst = 1'b0;
    step(1'b1);

    // Fall-through into an empty buffer.
    set_in(0, 0, 0, 1, 7, 32'h3F80_0000, 7);
    step(1'b0);
    set_in(0, 0, 0, 0, 0, 0, 7);
    step(1'b1);

    // CPU owns the port while two accelerator writes queue, then drain in order.
    for (int c = 0; c < 5; c++) begin
      set_in(c < 3, 3, 5, c < 2, 5'(8 + c), 32'hA000_0000 + 32'(c), 8);
      step(1'b0);
    end

    // Back-pressure: five pushes under continuous CPU writes.
    k = 0;
    for (int c = 0; c < 6; c++) begin
      acc_take = (k < 5) && (q.size() < DEPTH);
      set_in(1, 2, 32'(c), k < 5, 5'(20 + k), 32'h100 + 32'(k), 5'(20 + k));
      step(1'b0);
      if (acc_take) k++;
    end
    for (int c = 0; c < 8; c++) begin
      acc_take = (k < 5) && (q.size() < DEPTH);
      set_in(0, 0, 0, k < 5, 5'(20 + k), 32'h100 + 32'(k), 5'(20 + c % 5));
      step(1'b0);
      if (acc_take) k++;
    end

    // WAW kill: buffered x10 overwritten by CPU, killed entry drains silently.
    set_in(1, 1, 32'h11, 1, 10, 32'h4150_0000, 10);
    step(1'b0);
    set_in(1, 10, 32'hC000_0000, 0, 0, 0, 10);
    step(1'b0);
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 10);
      step(1'b0);
    end

    // Youngest-match bypass and x0 read.
    set_in(1, 1, 32'h22, 1, 12, 32'hAAAA_0001, 12);
    step(1'b0);
    set_in(1, 2, 32'h33, 1, 12, 32'hBBBB_0002, 12);
    step(1'b0);
    set_in(1, 3, 32'h44, 0, 0, 0, 12);
    step(1'b0);
    set_in(1, 3, 32'h45, 0, 0, 0, 13);
    step(1'b0);
    set_in(1, 3, 32'h46, 0, 0, 0, 0);
    step(1'b0);

    // Reset with three buffered entries (two already queued, one more now).
    set_in(1, 4, 32'h55, 1, 14, 32'hCCCC_0003, 14);
    step(1'b0);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 14);
    step(1'b0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 5'(12 + c));
      step(1'b1);
    end
    set_in(0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0);
    step(1'b0);

    // Random traffic over a narrow address range to exercise kills and bypass hits.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      set_in($urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 9) < 6, 5'($urandom_range(0, 15)), $urandom,
             5'($urandom_range(0, 15)));
      step(1'b0);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
